// File: rtl/drap_pkg.sv
// Shared widths, constants and the fetch-entry type for the DRAP instruction fetch path.
package drap_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] RESET_PC = 7'h00;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/drap_skid_fifo.sv
// Small skid FIFO of {pc, word} fetch entries; the head is presented directly from registered storage.
module drap_skid_fifo
    import drap_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_word,
    input  logic              pop,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_word,
    output logic [CNT_W-1:0]  count
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (32'(ptr) == DEPTH - 1) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: push_pc, word: push_word};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_pc    = mem_q[rd_ptr_q].pc;
    assign head_word  = mem_q[rd_ptr_q].word;
    assign count      = count_q;

endmodule

// File: rtl/drap_ifetch.sv
// DRAP instruction fetch: drives the ROM address, absorbs its one-cycle latency and feeds decode
// through a skid FIFO; handles sequential stepping and branch/jump redirect with flush.
module drap_ifetch
    import drap_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] iROMaddr,
    input  logic [DATA_W-1:0] iROMdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [OCC_W-1:0]  occupancy;
    logic              pop;
    logic              push;
    logic              issue;

    // A new fetch is only issued when its returning word is guaranteed a FIFO slot,
    // so the ROM never needs to be stalled and no word is ever dropped except on redirect.
    always_comb begin
        iROMaddr      = redirect_valid ? word_align(redirect_pc) : pc_q;
        pop           = instr_valid & instr_ready;
        push          = inflight_q & ~redirect_valid;
        occupancy     = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue         = redirect_valid | (occupancy < OCC_W'(DEPTH));
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (issue) begin
            pc_d          = iROMaddr + PC_STEP;
            inflight_pc_d = iROMaddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    drap_skid_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_pc   (inflight_pc_q),
        .push_word (iROMdata),
        .pop       (pop),
        .head_valid(instr_valid),
        .head_pc   (instr_pc),
        .head_word (instr),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_drap_ifetch.sv
// Bench for drap_ifetch: ROM model with registered address, directed scenarios plus random
// ready/redirect/reset traffic checked against a stream-level reference model.
module tb_drap_ifetch;
    import drap_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  iROMaddr;
    logic [31:0] iROMdata;
    logic        redirect_valid = 1'b0;
    logic [6:0]  redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [6:0]  instr_pc;

    always #5 clk = ~clk;

    drap_ifetch #(
        .DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iROMaddr      (iROMaddr),
        .iROMdata      (iROMdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    // ROM: address registered on the clock, not reset
    logic [31:0] rom [32];
    logic [6:0]  rom_addr_q;
    always @(posedge clk) rom_addr_q <= iROMaddr;
    assign iROMdata = rom[rom_addr_q[6:2]];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: the delivered stream is the consecutive word sequence starting at the
    // last restart point (reset or redirect target); output appears exactly 2 cycles after a
    // restart and never bubbles afterwards; fetch stalls only when decode stalls.
    logic [6:0]  exp_pc;
    logic [6:0]  exp_addr;
    int          age;
    logic        held_prev;
    logic [6:0]  prev_pc;
    logic [31:0] prev_instr;
    logic        issued;
    logic [6:0]  cur_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", instr_valid, 1'b0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 7'h0);
            if (!redirect_valid) chk("rst_addr", iROMaddr, RESET_PC);
            exp_pc    = RESET_PC;
            exp_addr  = RESET_PC;
            age       = 0;
            held_prev = 1'b0;
        end else begin
            chk("valid_timing", instr_valid, age >= 2);
            cur_addr = redirect_valid ? {redirect_pc[6:2], 2'b00} : exp_addr;
            chk(redirect_valid ? "addr_redirect" : "addr_seq", iROMaddr, cur_addr);
            if (held_prev) begin
                chk("stall_pc", instr_pc, prev_pc);
                chk("stall_instr", instr, prev_instr);
            end
            if (instr_valid && instr_ready) begin
                chk("pc", instr_pc, exp_pc);
                chk("instr", instr, rom[exp_pc[6:2]]);
                exp_pc = exp_pc + 7'd4;
            end
            issued     = redirect_valid || age < 2 || instr_ready;
            exp_addr   = issued ? cur_addr + 7'd4 : cur_addr;
            held_prev  = instr_valid && !instr_ready && !redirect_valid;
            prev_pc    = instr_pc;
            prev_instr = instr;
            if (redirect_valid) begin
                exp_pc = {redirect_pc[6:2], 2'b00};
                age    = 1;
            end else if (age < 1000) begin
                age++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int cycles);
        step();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("async_valid", instr_valid, 1'b0);
        chk("async_instr_pc", instr_pc, 7'h0);
        chk("async_addr", iROMaddr, RESET_PC);
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_head(input logic [6:0] pc);
        int n = 0;
        while (!(instr_valid && instr_pc == pc) && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("wait_head_timeout", {instr_valid, instr_pc}, {1'b1, pc});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[0] = 32'h02734820;
        rom[1] = 32'h02734820;
        rom[2] = 32'h02364820;
        rom[3] = 32'h8d280000;

        // Reset release, steady ready: first valid in cycle 2, then one per cycle
        do_reset(2);
        step();
        chk("c1_valid", instr_valid, 1'b0);
        step();
        chk("c2_valid", instr_valid, 1'b1);
        chk("c2_pc", instr_pc, 7'h00);
        chk("c2_instr", instr, 32'h02734820);
        step();
        chk("c3_pc", instr_pc, 7'h04);
        step();
        chk("c4_pc", instr_pc, 7'h08);
        chk("c4_instr", instr, 32'h02364820);
        step();
        chk("c5_pc", instr_pc, 7'h0C);
        chk("c5_instr", instr, 32'h8d280000);

        // Decode stall for 5 cycles with 04 at the head
        do_reset(1);
        wait_head(7'h04);
        instr_ready = 1'b0;
        repeat (5) step();
        chk("stall_head_pc", instr_pc, 7'h04);
        chk("stall_head_instr", instr, 32'h02734820);
        instr_ready = 1'b1;
        step();
        chk("release_pc0", instr_pc, 7'h08);
        step();
        chk("release_pc1", instr_pc, 7'h0C);

        // Redirect to an unaligned target while 04 is at the head
        do_reset(1);
        wait_head(7'h04);
        redirect_valid = 1'b1;
        redirect_pc    = 7'h0E;
        step();
        redirect_valid = 1'b0;
        chk("redir_bubble", instr_valid, 1'b0);
        step();
        chk("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 7'h0C);
        chk("redir_instr", instr, 32'h8d280000);

        // Sequential wrap from 7C to 00
        redirect_valid = 1'b1;
        redirect_pc    = 7'h7C;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc7c", instr_pc, 7'h7C);
        step();
        chk("wrap_pc00", instr_pc, 7'h00);
        chk("wrap_instr", instr, 32'h02734820);

        // Reset pulse mid-stream
        do_reset(1);
        step();
        chk("rst_pulse_c1", instr_valid, 1'b0);
        step();
        chk("rst_pulse_c2", instr_valid, 1'b1);
        chk("rst_pulse_pc", instr_pc, 7'h00);

        // Redirect together with a handshake while the FIFO holds two entries
        instr_ready = 1'b0;
        repeat (3) step();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 7'h08;
        step();
        redirect_valid = 1'b0;
        chk("redir_hs_bubble", instr_valid, 1'b0);
        step();
        chk("redir_hs_pc", instr_pc, 7'h08);
        chk("redir_hs_instr", instr, 32'h02364820);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = 7'($urandom);
        end
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
